// File: rtl/chkmon_pkg.sv
// chkmon_pkg: shared types and defaults for chkbit_cycle_monitor.
// Holds the FSM state enum, default START/STOP/EXP codes and a saturating increment.
package chkmon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE,
      ST_TOUT
   } state_e;

   localparam logic [15:0] DEF_START = 16'hAB40;
   localparam logic [15:0] DEF_STOP  = 16'hAB51;
   localparam logic [15:0] DEF_EXP0  = 16'h003E;
   localparam logic [15:0] DEF_EXP1  = 16'h0044;
   localparam logic [15:0] DEF_EXP2  = 16'h004A;
   localparam logic [15:0] DEF_EXP3  = 16'h0050;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/chkmon_fifo.sv
// chkmon_fifo: first-word fall-through event FIFO, DEPTH entries of W bits.
// Ports: wb_clk_i, wb_rst_i (sync, high), flush_i, push_i/push_data_i, pop_i,
//        head_o, full_o, empty_o, count_o.
module chkmon_fifo
   import chkmon_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [W-1:0]             push_data_i,
   input  logic                     pop_i,
   output logic [W-1:0]             head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_head;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic [AW-1:0] w_rp_nx;
   logic [W-1:0]  w_head_nx;

   assign w_full  = (r_cnt == CW'(DEPTH));
   assign w_empty = (r_cnt == '0);
   assign w_pop   = pop_i & ~w_empty;
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign w_push  = push_i & (~w_full | w_pop);
   assign w_rp_nx = r_rp + AW'(1);

   // head is a register so it keeps the last popped word once empty
   always_comb begin
      w_head_nx = r_head;
      if (w_pop) begin
         if (r_cnt > CW'(1))
            w_head_nx = r_mem[w_rp_nx];
         else if (w_push)
            w_head_nx = push_data_i;
      end else if (w_empty && w_push) begin
         w_head_nx = push_data_i;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i && !flush_i && w_push)
         r_mem[r_wp] <= push_data_i;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_cnt  <= '0;
         r_head <= '0;
      end else if (flush_i) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push)
            r_wp <= r_wp + AW'(1);
         if (w_pop)
            r_rp <= w_rp_nx;
         r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
         r_head <= w_head_nx;
      end
   end

   assign head_o  = r_head;
   assign full_o  = w_full;
   assign empty_o = w_empty;
   assign count_o = r_cnt;

endmodule

// File: rtl/chkbit_cycle_monitor.sv
// chkbit_cycle_monitor: times a firmware window marked by GPIO checkbit codes,
// queues intermediate codes. Optional expected-sequence check: CHKMON_EXPECT_EN.
// Ports: wb_clk_i, wb_rst_i, checkbits_i[15:0], clear_i, evt_rd_i -> evt_data_o,
//        evt_empty_o, evt_count_o, cycles_o, busy_o, done_o, timeout_o,
//        overflow_o (+ pass_o, mismatch_o with CHKMON_EXPECT_EN).
module chkbit_cycle_monitor
   import chkmon_pkg::*;
#(
   parameter logic [15:0] START_CODE     = DEF_START,
   parameter logic [15:0] STOP_CODE      = DEF_STOP,
   parameter int          DEPTH          = 4,
   parameter int          TIMEOUT_CYCLES = 375000
`ifdef CHKMON_EXPECT_EN
   ,
   parameter logic [15:0] EXP0           = DEF_EXP0,
   parameter logic [15:0] EXP1           = DEF_EXP1,
   parameter logic [15:0] EXP2           = DEF_EXP2,
   parameter logic [15:0] EXP3           = DEF_EXP3
`endif
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic [15:0]            checkbits_i,
   input  logic                   clear_i,
   input  logic                   evt_rd_i,
   output logic [15:0]            evt_data_o,
   output logic                   evt_empty_o,
   output logic [$clog2(DEPTH):0] evt_count_o,
   output logic [31:0]            cycles_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   timeout_o,
   output logic                   overflow_o
`ifdef CHKMON_EXPECT_EN
   ,
   output logic                   pass_o,
   output logic                   mismatch_o
`endif
);

   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_e      r_state;
   state_e      w_state_nx;
   logic [31:0] r_cycles;
   logic [31:0] w_cyc_nx;
   logic [15:0] r_prev;
   logic [15:0] r_last;
   logic        r_ovf;

   logic        w_acc;
   logic        w_is_start;
   logic        w_is_stop;
   logic        w_push;
   logic        w_pop;
   logic        w_full;

   // two equal samples in a row filter multi-bit GPIO skew
   assign w_acc      = ~clear_i & (checkbits_i == r_prev) &
                       (checkbits_i != r_last);
   assign w_is_start = (checkbits_i == START_CODE);
   assign w_is_stop  = (checkbits_i == STOP_CODE);
   assign w_pop      = evt_rd_i & ~clear_i;

   always_comb begin
      w_state_nx = r_state;
      w_cyc_nx   = r_cycles;
      w_push     = 1'b0;
      if (clear_i) begin
         w_state_nx = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_acc && w_is_start) begin
                  w_state_nx = ST_RUN;
                  w_cyc_nx   = '0;
               end
            end
            ST_RUN: begin
               w_push = w_acc & ~w_is_start & ~w_is_stop;
               // the stop cycle is counted so cycles_o equals the spacing
               if (w_acc && w_is_stop) begin
                  w_state_nx = ST_DONE;
                  w_cyc_nx   = sat_inc(r_cycles);
               end else if (r_cycles == TO_LAST) begin
                  w_state_nx = ST_TOUT;
               end else begin
                  w_cyc_nx = sat_inc(r_cycles);
               end
            end
            ST_DONE: ;
            ST_TOUT: ;
            default: w_state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state  <= ST_IDLE;
         r_cycles <= '0;
         r_prev   <= '0;
         r_last   <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_cycles <= w_cyc_nx;
         r_prev   <= checkbits_i;
         if (w_acc)
            r_last <= checkbits_i;
         if (clear_i)
            r_ovf <= 1'b0;
         else if (w_push && w_full && !evt_rd_i)
            r_ovf <= 1'b1;
      end
   end

   chkmon_fifo #(
      .DEPTH (DEPTH),
      .W     (16)
   ) u_fifo (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .flush_i     (clear_i),
      .push_i      (w_push),
      .push_data_i (checkbits_i),
      .pop_i       (w_pop),
      .head_o      (evt_data_o),
      .full_o      (w_full),
      .empty_o     (evt_empty_o),
      .count_o     (evt_count_o)
   );

   assign cycles_o   = r_cycles;
   assign busy_o     = (r_state == ST_RUN);
   assign done_o     = (r_state == ST_DONE);
   assign timeout_o  = (r_state == ST_TOUT);
   assign overflow_o = r_ovf;

`ifdef CHKMON_EXPECT_EN
   logic [2:0]  r_npush;
   logic        r_mis;
   logic [15:0] w_exp;

   always_comb begin
      unique case (r_npush[1:0])
         2'd0: w_exp = EXP0;
         2'd1: w_exp = EXP1;
         2'd2: w_exp = EXP2;
         2'd3: w_exp = EXP3;
         default: w_exp = EXP0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || clear_i) begin
         r_npush <= '0;
         r_mis   <= 1'b0;
      end else if (w_push) begin
         if (!r_npush[2] && checkbits_i != w_exp)
            r_mis <= 1'b1;
         if (r_npush != 3'd7)
            r_npush <= r_npush + 3'd1;
      end
   end

   assign mismatch_o = r_mis;
   assign pass_o     = done_o & ~r_mis & ~r_ovf & (r_npush == 3'd4);
`endif

endmodule

// File: doc/chkbit_cycle_monitor.md
CHKBIT_CYCLE_MONITOR -- requirements
Module: chkbit_cycle_monitor

Interface
REQ-001 Parameter START_CODE, default 16'hAB40: checkbit code that opens a measurement window.
REQ-002 Parameter STOP_CODE, default 16'hAB51: checkbit code that closes the window.
REQ-003 Parameter DEPTH, default 4: result FIFO entries, power of two, 2..16.
REQ-004 Parameter TIMEOUT_CYCLES, default 375000: RUN-state cycle limit.
REQ-005 wb_clk_i  in  1  sole clock; every flop is on its rising edge.
REQ-006 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-007 checkbits_i  in  16  firmware code from mprj_io[31:16].
REQ-008 clear_i  in  1  single-cycle pulse; returns the block to IDLE.
REQ-009 evt_rd_i  in  1  pops the FIFO head.
REQ-010 evt_data_o  out  16  FIFO head (first-word fall-through); evt_empty_o  out  1; evt_count_o  out  $clog2(DEPTH)+1.
REQ-011 cycles_o  out  32  window cycle count; busy_o, done_o, timeout_o, overflow_o  out  1 each.

Function
REQ-012 Qualify: a code is accepted in the cycle where checkbits_i equals its previous-cycle sample and differs from the last accepted code; this filters multi-bit GPIO skew.
REQ-013 States: IDLE, RUN, DONE, TOUT; busy_o=RUN, done_o=DONE, timeout_o=TOUT.
REQ-014 IDLE->RUN on acceptance of START_CODE; cycles_o=0 in the cycle after the transition.
REQ-015 In RUN, cycles_o increments by 1 per cycle and saturates at 32'hFFFFFFFF.
REQ-016 In RUN, an accepted code other than START_CODE or STOP_CODE is pushed to the FIFO, visible on evt_data_o the next cycle.
REQ-017 In RUN, an accepted START_CODE is ignored and does not restart the count.
REQ-018 RUN->DONE on acceptance of STOP_CODE; cycles_o freezes at its value from that cycle.
REQ-019 RUN->TOUT when cycles_o reaches TIMEOUT_CYCLES-1; cycles_o then freezes.
REQ-020 DONE and TOUT are held until clear_i or wb_rst_i; accepted codes are ignored.
REQ-021 Push when full with no pop: the entry is dropped and overflow_o sets (sticky).
REQ-022 Push and pop in the same cycle when full: both succeed and the count is unchanged.
REQ-023 Pop when empty has no effect; evt_data_o holds its last value.
REQ-024 clear_i, in any state including mid-RUN: next state IDLE; FIFO flushed; overflow_o and the mismatch flag cleared; cycles_o keeps its value until the next START_CODE.
REQ-025 clear_i has priority over any simultaneous accept, push or pop.

Reset
REQ-026 wb_rst_i sets: state IDLE; cycles_o=0; FIFO empty (evt_empty_o=1, evt_count_o=0, evt_data_o=0); busy_o, done_o, timeout_o and overflow_o all 0; last-accepted code=16'h0000.
REQ-027 wb_rst_i overrides clear_i and all other inputs.

Configuration
REQ-028 Macro CHKMON_EXPECT_EN: when defined, the block adds parameter EXP0..EXP3 (defaults 16'h003E, 16'h0044, 16'h004A, 16'h0050) and outputs pass_o and mismatch_o.
REQ-029 With CHKMON_EXPECT_EN defined, the n-th push (n<4) is compared with EXPn; any difference sets mismatch_o (sticky).
REQ-030 With CHKMON_EXPECT_EN defined, pass_o = done_o & ~mismatch_o & ~overflow_o & (exactly 4 pushes).
REQ-031 Without CHKMON_EXPECT_EN, pass_o and mismatch_o are absent and no compare logic is built.

Structure
REQ-032 Package chkmon_pkg holds the state enum, the default START/STOP codes and the default EXP0..EXP3 values.
REQ-033 The FIFO is a separate sub-module, chkmon_fifo (DEPTH, 16-bit width, full/empty/count outputs).

Verification
REQ-034 Hold AB40 for 3 cycles, hold AB51 -> busy_o=1 after AB40; done_o=1 after AB51; cycles_o equals the AB40-to-AB51 acceptance spacing.
REQ-035 Drive AB40, then 003E, 0044, 004A, 0050 (5 cycles each), then AB51 -> FIFO pops 003E, 0044, 004A, 0050 in order; pass_o=1 with CHKMON_EXPECT_EN.
REQ-036 Drive AB40, then a 1-cycle glitch to 1234, then 003E -> only 003E is pushed.
REQ-037 Push 6 codes with DEPTH=4 and no pops -> evt_count_o=4, overflow_o=1; first 4 codes retained.
REQ-038 TIMEOUT_CYCLES=100, AB40 with no AB51 -> timeout_o=1, cycles_o=99.
REQ-039 clear_i mid-RUN with 2 entries queued -> IDLE, evt_empty_o=1; a following AB40 restarts with cycles_o=0.
